// File: rtl/stage1_fetch.sv
// ---------------------------------------------------------------------------
// stage1_fetch
//   Instruction fetch stage. Holds the PC and the IF/ID pipeline register and
//   applies next-PC selection requested by the decode controller.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   sstall            : decode hazard stall, freezes PC and IF/ID
//   pcInputSel        : next-PC source (00 adder, 01 jump, 10 return, 11 hold)
//   pcAdderInputASel  : adder operands (0: PC + 1, 1: pcID + sext(const_disp))
//   const_disp        : signed branch displacement of the decode instruction
//   jumpAddr          : absolute jump target
//   stackOut          : return address popped by decode
//   imemAddr          : instruction memory address (the PC register)
//   imemData          : instruction word read combinationally at imemAddr
//   instruction       : IF/ID instruction register
//   pcID              : PC of the instruction held in IF/ID
//   stackIn           : pcID + 1, return address for a call in decode
//   validID           : IF/ID holds a real instruction (0 = bubble)
//   flushCount        : saturating count of redirect flushes
// ---------------------------------------------------------------------------
module stage1_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        sstall,
    input  logic [1:0]  pcInputSel,
    input  logic        pcAdderInputASel,
    input  logic [7:0]  const_disp,
    input  logic [11:0] jumpAddr,
    input  logic [11:0] stackOut,
    output logic [11:0] imemAddr,
    input  logic [18:0] imemData,
    output logic [18:0] instruction,
    output logic [11:0] pcID,
    output logic [11:0] stackIn,
    output logic        validID,
    output logic [7:0]  flushCount
);

    localparam logic [18:0] NOP = 19'h7A000;

    typedef enum logic [1:0] {
        SEL_ADDER  = 2'b00,
        SEL_JUMP   = 2'b01,
        SEL_RETURN = 2'b10,
        SEL_HOLD   = 2'b11
    } pcSel_t;

    // IF/ID pipeline register contents
    typedef struct packed {
        logic [18:0] instr;
        logic [11:0] pc;
        logic        valid;
    } ifId_t;

    logic [11:0] pc;
    ifId_t       ifId;
    logic [7:0]  flushCnt;

    logic [11:0] addA;
    logic [11:0] addB;
    logic [11:0] addSum;
    logic [11:0] pcNext;
    logic        redirect;
    logic        advance;
    pcSel_t      sel;

    assign sel = pcSel_t'(pcInputSel);

    // Shared adder: sequential increment or PC-relative branch from the
    // instruction currently in decode. Wraps mod 4096.
    always_comb begin
        addA   = pcAdderInputASel ? ifId.pc : pc;
        addB   = pcAdderInputASel ? {{4{const_disp[7]}}, const_disp} : 12'd1;
        addSum = addA + addB;
    end

    always_comb begin
        pcNext = pc;
        unique case (sel)
            SEL_ADDER:  pcNext = addSum;
            SEL_JUMP:   pcNext = jumpAddr;
            SEL_RETURN: pcNext = stackOut;
            SEL_HOLD:   pcNext = pc;
        endcase
    end

    // A plain PC + 1 is not a redirect; anything that breaks sequential flow
    // squashes the word fetched this cycle.
    assign redirect = (sel == SEL_JUMP) || (sel == SEL_RETURN) ||
                      ((sel == SEL_ADDER) && pcAdderInputASel);

    // Stall wins over everything; decode re-presents its request after the
    // stall, so a redirect seen during a stall is not lost. Hold select
    // freezes the stage without counting a flush.
    assign advance = !sstall && (sel != SEL_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= '0;
            ifId.instr <= NOP;
            ifId.pc    <= '0;
            ifId.valid <= 1'b0;
            flushCnt   <= '0;
        end else if (advance) begin
            pc      <= pcNext;
            ifId.pc <= pc;
            if (redirect) begin
                ifId.instr <= NOP;
                ifId.valid <= 1'b0;
                if (flushCnt != 8'hFF)
                    flushCnt <= flushCnt + 8'd1;
            end else begin
                ifId.instr <= imemData;
                ifId.valid <= 1'b1;
            end
        end
    end

    assign imemAddr    = pc;
    assign instruction = ifId.instr;
    assign pcID        = ifId.pc;
    assign stackIn     = ifId.pc + 12'd1;
    assign validID     = ifId.valid;
    assign flushCount  = flushCnt;

endmodule

// File: tb/tb_stage1_fetch.sv
// Self-checking bench for stage1_fetch: a behavioural model of the fetch
// stage is compared against the DUT on every falling edge, with directed
// literal scenarios and a randomized phase.
module tb_stage1_fetch;

    localparam int NOPW = 'h7A000;

    logic        clk = 0;
    logic        rst = 0;
    logic        sstall = 0;
    logic [1:0]  pcInputSel = 0;
    logic        pcAdderInputASel = 0;
    logic [7:0]  const_disp = 0;
    logic [11:0] jumpAddr = 0;
    logic [11:0] stackOut = 0;
    logic [11:0] imemAddr;
    logic [18:0] imemData;
    logic [18:0] instruction;
    logic [11:0] pcID;
    logic [11:0] stackIn;
    logic        validID;
    logic [7:0]  flushCount;

    logic [18:0] mem [4096];

    int checks = 0;
    int failures = 0;

    stage1_fetch dut (
        .clk(clk), .rst(rst), .sstall(sstall), .pcInputSel(pcInputSel),
        .pcAdderInputASel(pcAdderInputASel), .const_disp(const_disp),
        .jumpAddr(jumpAddr), .stackOut(stackOut), .imemAddr(imemAddr),
        .imemData(imemData), .instruction(instruction), .pcID(pcID),
        .stackIn(stackIn), .validID(validID), .flushCount(flushCount)
    );

    assign imemData = mem[imemAddr];

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int mPc, mPcId, mInstr, mValid, mFc;

    function automatic bit isRedirect(int s, bit a);
        return (s == 1) || (s == 2) || (s == 0 && a);
    endfunction

    function automatic int target(int s, bit a, int d, int j, int st, int pc, int pcid);
        int disp;
        disp = (d >= 128) ? d - 256 : d;
        case (s)
            1: return j;
            2: return st;
            default: return a ? ((pcid + disp) & 'hFFF) : ((pc + 1) % 4096);
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPc <= 0; mPcId <= 0; mInstr <= NOPW; mValid <= 0; mFc <= 0;
        end else if (!sstall && pcInputSel != 2'b11) begin
            mPc   <= target(int'(pcInputSel), pcAdderInputASel, int'(const_disp),
                            int'(jumpAddr), int'(stackOut), mPc, mPcId);
            mPcId <= mPc;
            if (isRedirect(int'(pcInputSel), pcAdderInputASel)) begin
                mInstr <= NOPW;
                mValid <= 0;
                mFc    <= (mFc < 255) ? mFc + 1 : 255;
            end else begin
                mInstr <= int'(mem[mPc]);
                mValid <= 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        chk("imemAddr", int'(imemAddr), mPc);
        chk("instruction", int'(instruction), mInstr);
        chk("pcID", int'(pcID), mPcId);
        chk("stackIn", int'(stackIn), (mPcId + 1) % 4096);
        chk("validID", int'(validID), mValid);
        chk("flushCount", int'(flushCount), mFc);
    end

    // drive one cycle of inputs, then settle just after the rising edge
    task automatic step(input bit st, input int s, input bit a, input int d,
                        input int j, input int sk);
        sstall = st; pcInputSel = 2'(s); pcAdderInputASel = a;
        const_disp = 8'(d); jumpAddr = 12'(j); stackOut = 12'(sk);
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1;
        #2;
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 19'($urandom);
        mem[0] = 19'h00001; mem[1] = 19'h00002; mem[2] = 19'h00003;
        #1 rst = 1;
        #3;
        chk("rst_instruction", int'(instruction), 'h7A000);
        chk("rst_imemAddr", int'(imemAddr), 0);
        chk("rst_validID", int'(validID), 0);
        @(negedge clk);
        rst = 0;
        #1;

        // sequential fetch of 0..2
        step(0, 0, 0, 0, 0, 0);
        chk("seq0_instr", int'(instruction), 'h00001);
        chk("seq0_pcID", int'(pcID), 0);
        chk("seq0_stackIn", int'(stackIn), 1);
        chk("seq0_valid", int'(validID), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("seq1_instr", int'(instruction), 'h00002);
        chk("seq1_stackIn", int'(stackIn), 2);
        step(0, 0, 0, 0, 0, 0);
        chk("seq2_instr", int'(instruction), 'h00003);
        chk("seq2_pcID", int'(pcID), 2);
        chk("seq2_stackIn", int'(stackIn), 3);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("pre_br_pc", int'(imemAddr), 5);
        chk("pre_br_pcID", int'(pcID), 4);

        // relative branch -2 from pcID 4
        step(0, 0, 1, 'hFE, 0, 0);
        chk("br_pc", int'(imemAddr), 2);
        chk("br_instr", int'(instruction), 'h7A000);
        chk("br_valid", int'(validID), 0);
        chk("br_flush", int'(flushCount), 1);

        // absolute jump, then target fetch
        step(0, 1, 0, 0, 'h123, 0);
        chk("jmp_pc", int'(imemAddr), 'h123);
        chk("jmp_valid", int'(validID), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("jmp_tgt_instr", int'(instruction), int'(mem['h123]));
        chk("jmp_tgt_pcID", int'(pcID), 'h123);
        chk("jmp_tgt_valid", int'(validID), 1);

        // stall with a pending return: nothing moves
        for (int k = 0; k < 3; k++) begin
            step(1, 2, 0, 0, 0, 'h040);
            chk("stall_pc", int'(imemAddr), 'h124);
            chk("stall_pcID", int'(pcID), 'h123);
            chk("stall_instr", int'(instruction), int'(mem['h123]));
            chk("stall_flush", int'(flushCount), 2);
        end

        // hold select: no change, no flush count
        step(0, 3, 0, 0, 0, 0);
        chk("hold_pc", int'(imemAddr), 'h124);
        chk("hold_flush", int'(flushCount), 2);

        // wrap at 4095
        step(0, 1, 0, 0, 'hFFF, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_pc", int'(imemAddr), 0);
        chk("wrap_pcID", int'(pcID), 'hFFF);
        chk("wrap_stackIn", int'(stackIn), 0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if (i % 700 == 350) doReset();
            step($urandom_range(0, 4) == 0, int'($urandom_range(0, 3)),
                 1'($urandom), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
        end

        // flush counter saturation
        doReset();
        for (int i = 0; i < 256; i++) step(0, 1, 0, 0, int'($urandom_range(0, 4095)), 0);
        chk("sat_flush", int'(flushCount), 255);
        step(0, 2, 0, 0, 0, 'h040);
        chk("sat_hold_flush", int'(flushCount), 255);
        chk("ret_pc", int'(imemAddr), 'h040);

        // asynchronous reset mid-cycle
        sstall = 1; pcInputSel = 2'b01;
        #1 rst = 1;
        #1;
        chk("arst_pc", int'(imemAddr), 0);
        chk("arst_instr", int'(instruction), 'h7A000);
        chk("arst_pcID", int'(pcID), 0);
        chk("arst_valid", int'(validID), 0);
        chk("arst_flush", int'(flushCount), 0);
        @(negedge clk);
        rst = 0;
        #1;
        step(0, 0, 0, 0, 0, 0);
        chk("post_rst_instr", int'(instruction), int'(mem[0]));
        chk("post_rst_pcID", int'(pcID), 0);
        chk("post_rst_pc", int'(imemAddr), 1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage1_fetch.md
STAGE1_FETCH -- requirements
Module: stage1_fetch

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 sstall  input  1  hazard stall from decode; holds PC and IF/ID register.
REQ-004 pcInputSel  input  2  next-PC select from decode controller.
REQ-005 pcAdderInputASel  input  1  PC adder operand select from decode controller.
REQ-006 const_disp  input  8  branch displacement of the instruction in decode, two's complement.
REQ-007 jumpAddr  input  12  absolute jump target of the instruction in decode.
REQ-008 stackOut  input  12  return address popped by decode.
REQ-009 imemAddr  output  12  instruction memory address, equal to the PC register.
REQ-010 imemData  input  19  instruction word; combinational read of imemAddr.
REQ-011 instruction  output  19  IF/ID instruction register, feeding decode.
REQ-012 pcID  output  12  PC of the instruction held in IF/ID.
REQ-013 stackIn  output  12  return address for a call in decode, equal to pcID + 1 mod 4096.
REQ-014 validID  output  1  1 = IF/ID holds a fetched instruction; 0 = bubble.
REQ-015 flushCount  output  8  count of redirect flushes since reset, saturating at 255.

Function
REQ-016 PC adder: operand A = pcAdderInputASel ? pcID : PC; operand B = pcAdderInputASel ? sign-extended const_disp : 12'd1; sum is 12 bits and wraps mod 4096.
REQ-017 Next PC selection:
- pcInputSel 00: adder sum.
- 01: jumpAddr.
- 10: stackOut.
- 11: PC unchanged.
REQ-018 redirect = (pcInputSel == 01) | (pcInputSel == 10) | (pcInputSel == 00 & pcAdderInputASel).
REQ-019 Normal cycle (sstall=0, redirect=0):
- PC <= PC + 1.
- instruction <= imemData.
- pcID <= PC.
- validID <= 1.
REQ-020 Redirect cycle (sstall=0, redirect=1):
- PC <= selected target.
- instruction <= NOP 19'h7A000 (6'b111101 followed by 13 zeros).
- validID <= 0.
- pcID <= PC.
- flushCount increments unless it equals 255.
REQ-021 pcInputSel 11 with sstall=0: PC, IF/ID and validID hold; not counted as a redirect.
REQ-022 Stall cycle (sstall=1):
- PC, instruction, pcID and validID hold.
- Stall takes priority over redirect; the decode stage issues a NOP during a stall, so no redirect is lost.
REQ-023 Fetch-to-decode latency is 1 cycle: the instruction at address A appears on instruction in the cycle after imemAddr = A, absent stall or redirect.
REQ-024 Branch penalty is exactly one bubble: the instruction fetched in the redirect cycle is discarded, and the target instruction reaches IF/ID one cycle later.
REQ-025 stackIn, imemAddr and the adder path are purely combinational from the registers and inputs.
REQ-026 PC wrap: PC = 4095 with sequential fetch -> PC = 0, with no flag.

Reset
REQ-027 While rst=1, independent of clk:
- PC = 0.
- instruction = 19'h7A000.
- pcID = 0.
- validID = 0.
- flushCount = 0.
REQ-028 rst asserted mid-stall or mid-redirect overrides all pending updates. The first rising edge after rst falls fetches address 0.

Verification
REQ-029 Reset then 3 free cycles with imem[0..2] = 19'h00001, 19'h00002, 19'h00003 -> instruction = 00001, 00002, 00003 on successive cycles; pcID = 0, 1, 2; validID = 1; stackIn = 1, 2, 3.
REQ-030 PC = 5, pcID = 4, pcAdderInputASel=1, const_disp = 8'hFE, pcInputSel = 00 -> next PC = 2; instruction = 7A000; validID = 0; flushCount = 1.
REQ-031 pcInputSel = 01, jumpAddr = 12'h123 -> next PC = 123; bubble in IF/ID; following cycle instruction = imem[123], pcID = 123.
REQ-032 sstall=1 for 3 cycles with pcInputSel = 10, stackOut = 12'h040 -> PC, instruction and pcID unchanged for all 3 cycles; flushCount unchanged.
REQ-033 PC = 12'hFFF, sequential -> PC = 0 next cycle; pcID = FFF; stackIn = 000.
REQ-034 256 consecutive jump redirects -> flushCount = 255, with no wrap; rst asserted asynchronously mid-cycle -> all outputs at REQ-027 values immediately.
